mem_access_stage: RTL

MEM-stage controller between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns a load or store into a req/ack transaction on a multi-cycle data-memory port. It aligns and extends load data and generates byte enables for stores. It stalls the pipeline until the access completes, and its Stall output drives the enable of MEM/WB and of all upstream stages.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/load_align.sv | 31 +++
 rtl/mem_access_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: access-size encodings, FSM states and
// the store-lane / byte-enable / alignment helpers.
package mips_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } mem_state_t;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SIZE_BYTE: byte_enable = 4'b0001 << addr;
            SIZE_HALF: byte_enable = addr[1] ? 4'b1100 : 4'b0011;
            default:   byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: store_lanes = {4{wdata[7:0]}};
            SIZE_HALF: store_lanes = {2{wdata[15:0]}};
            default:   store_lanes = wdata;
        endcase
    endfunction

    // Size 2'b11 is handled as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr[0];
            default:   is_misaligned = (addr != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension of the returned word.
    always_comb begin
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_addr)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        case (i_size)
            SIZE_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            default:   o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: issues req/ack data-memory transactions, aligns load
// data and stalls the pipeline until each access completes or times out.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [31:0] WriteRegister,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBe,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        MemtoReg_Out,
    output logic        RegWrite_Out,
    output logic [31:0] ALUResult_Out,
    output logic [31:0] WriteRegister_Out,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AlignError,
    output logic        BusError
);

    localparam logic             TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_abort;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_read_data;
    logic             r_align_err;
    logic             r_bus_err;

    logic        w_access;
    logic        w_write_op;
    logic        w_align_fault;
    logic        w_issue;
    logic        w_timeout;
    logic [31:0] w_load_data;
    logic        w_stall;
    logic        w_regwrite_out;

    assign w_access      = MemRead | MemWrite;
    assign w_write_op    = MemWrite & ~MemRead;
    assign w_align_fault = w_access & is_misaligned(MemSize, ALUResult[1:0]);
    assign w_issue       = w_access & ~w_align_fault;
    assign w_timeout     = TO_EN & (r_cnt == TO_LAST);

    load_align u_load_align (
        .i_rdata  (MemRData),
        .i_addr   (ALUResult[1:0]),
        .i_size   (MemSize),
        .i_signed (MemSigned),
        .o_data   (w_load_data)
    );

    // Stall and write-back gating follow the current state.
    always_comb begin
        w_stall        = 1'b0;
        w_regwrite_out = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall        = w_issue;
                w_regwrite_out = RegWrite & ~w_align_fault;
            end
            ST_WAIT: begin
                w_stall        = 1'b1;
                w_regwrite_out = RegWrite & ~r_abort;
            end
            ST_DONE: begin
                w_stall        = 1'b0;
                w_regwrite_out = RegWrite & ~r_abort;
            end
            default: begin
                w_stall        = 1'b0;
                w_regwrite_out = 1'b0;
            end
        endcase
    end

    // Access FSM with registered memory-port, load-data and error outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_abort     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_mem_be    <= 4'b0000;
            r_read_data <= 32'h0000_0000;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_write_op;
                        r_mem_addr  <= {ALUResult[31:2], 2'b00};
                        r_mem_wdata <= store_lanes(MemSize, WriteData);
                        r_mem_be    <= byte_enable(MemSize, ALUResult[1:0]);
                        r_cnt       <= '0;
                        r_state     <= ST_WAIT;
                    end else begin
                        r_align_err <= w_align_fault;
                    end
                end
                ST_WAIT: begin
                    if (MemAck) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_read_data <= w_load_data;
                        end
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_abort   <= 1'b1;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_cnt   <= '0;
                    r_abort <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign MemReq            = r_mem_req;
    assign MemWe             = r_mem_we;
    assign MemAddr           = r_mem_addr;
    assign MemWData          = r_mem_wdata;
    assign MemBe             = r_mem_be;
    assign ReadData          = r_read_data;
    assign AlignError        = r_align_err;
    assign BusError          = r_bus_err;
    assign Stall             = w_stall;
    assign RegWrite_Out      = w_regwrite_out;
    assign MemtoReg_Out      = MemtoReg;
    assign ALUResult_Out     = ALUResult;
    assign WriteRegister_Out = WriteRegister;

endmodule
